// File: rtl/bus_arbiter_pkg.sv
// Shared types and sizing helpers for the single-beat bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // The timeout counter only ever needs to reach TIMEOUT_CYCLES-1.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: searches upward from i_last_grant+1 with wrap.
module rr_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter  int NUM_MASTERS = 4,
    localparam int IDX_W       = idx_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_last_grant,
    output logic [NUM_MASTERS-1:0] o_grant_oh,
    output logic [IDX_W-1:0]       o_grant_idx,
    output logic                   o_valid
);

    logic [IDX_W-1:0]       w_cand [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] w_hit;

    // w_cand[gi] is the master at search position gi; position 0 has highest priority.
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
            assign w_cand[gi] = IDX_W'((int'(i_last_grant) + 1 + gi) % NUM_MASTERS);
            assign w_hit[gi]  = i_req[w_cand[gi]];
        end
    endgenerate

    always_comb begin
        o_grant_idx = '0;
        o_valid     = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                o_grant_idx = w_cand[i];
                o_valid     = 1'b1;
            end
        end
        o_grant_oh = NUM_MASTERS'(o_valid) << o_grant_idx;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of a single-beat bus: holds the grant for a whole transaction,
// times out a silent slave with an error return, and registers read data back.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter  int NUM_MASTERS    = 4,
    parameter  int ADDR_WIDTH     = 32,
    parameter  int DATA_WIDTH     = 32,
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int IDX_W          = idx_width(NUM_MASTERS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS-1:0]            m_rnw,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]            m_done,
    output logic                              m_err,
    output logic [DATA_WIDTH-1:0]             m_rdata,
    output logic                              bus_valid,
    output logic                              bus_rnw,
    output logic [ADDR_WIDTH-1:0]             bus_addr,
    output logic [DATA_WIDTH-1:0]             bus_wdata,
    input  logic [DATA_WIDTH-1:0]             bus_rdata,
    input  logic                              bus_ready,
    output logic [IDX_W-1:0]                  grant_id,
    output logic                              busy
);

    localparam int              CNT_W    = cnt_width(TIMEOUT_CYCLES);
    localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_e                 r_state;
    state_e                 w_state_next;
    logic [IDX_W-1:0]       r_grant_id;
    logic [NUM_MASTERS-1:0] r_grant_oh;
    logic [IDX_W-1:0]       r_last_grant;
    logic                   r_rnw;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic                   r_err;
    logic [CNT_W-1:0]       r_cnt;

    logic [ADDR_WIDTH-1:0]  w_addr  [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  w_wdata [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] w_win_oh;
    logic [IDX_W-1:0]       w_win_idx;
    logic                   w_any;
    logic                   w_timeout;

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
            assign w_addr[gi]  = m_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata[gi] = m_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr (
        .i_req        (m_req),
        .i_last_grant (r_last_grant),
        .o_grant_oh   (w_win_oh),
        .o_grant_idx  (w_win_idx),
        .o_valid      (w_any)
    );

    assign w_timeout = TO_EN && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_state_next = ST_BUSY;
            ST_BUSY: if (bus_ready || w_timeout) w_state_next = ST_RESP;
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Decoded straight from the state register so a reset removes them immediately.
    always_comb begin
        bus_valid = (r_state == ST_BUSY);
        busy      = (r_state != ST_IDLE);
        m_done    = (r_state == ST_RESP) ? r_grant_oh : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_id   <= '0;
            r_grant_oh   <= '0;
            // Last grant starts at the top index so the first search begins at master 0.
            r_last_grant <= IDX_W'(NUM_MASTERS - 1);
            r_rnw        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_any) begin
                        r_grant_id <= w_win_idx;
                        r_grant_oh <= w_win_oh;
                        r_rnw      <= m_rnw[w_win_idx];
                        r_addr     <= w_addr[w_win_idx];
                        r_wdata    <= w_wdata[w_win_idx];
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (bus_ready) begin
                        if (r_rnw) r_rdata <= bus_rdata;
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                ST_RESP: begin
                    r_cnt        <= '0;
                    r_last_grant <= r_grant_id;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign grant_id  = r_grant_id;
    assign bus_rnw   = r_rnw;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign m_rdata   = r_rdata;
    assign m_err     = r_err;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter: a transaction-level round-robin/timeout model checks every grant.
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_req, m_rnw, m_done;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic            m_err;
    logic [DW-1:0]   m_rdata;
    logic            bus_valid, bus_rnw, bus_ready, busy;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_wdata, bus_rdata;
    logic [1:0]      grant_id;

    always #5 clk = ~clk;

    bus_arbiter #(
        .NUM_MASTERS    (N),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_req     (m_req),
        .m_rnw     (m_rnw),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_done    (m_done),
        .m_err     (m_err),
        .m_rdata   (m_rdata),
        .bus_valid (bus_valid),
        .bus_rnw   (bus_rnw),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_txn = 0;
    logic [AW-1:0] addr_a  [N];
    logic [DW-1:0] wdata_a [N];
    logic          rnw_a   [N];
    int            model_last;
    logic [DW-1:0] model_rdata;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (txn %0d)", tag, got, exp, n_txn);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic rnw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rnw_a[i]   = rnw;
        addr_a[i]  = a;
        wdata_a[i] = d;
        m_req[i]   = 1'b1;
        m_rnw[i]   = rnw;
        m_addr[i*AW +: AW]  = a;
        m_wdata[i*DW +: DW] = d;
    endtask

    // Non-owners get garbage attributes so a wrong-master mux shows up.
    task automatic clear_req(input int i);
        m_req[i] = 1'b0;
        m_rnw[i] = 1'($urandom_range(0, 1));
        m_addr[i*AW +: AW]  = $urandom;
        m_wdata[i*DW +: DW] = $urandom;
    endtask

    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int off = 1; off <= N; off++) begin
            if (req[(last + off) % N]) return (last + off) % N;
        end
        return -1;
    endfunction

    // Starts in an IDLE cycle with at least one request pending; ready arrives in busy cycle d.
    task automatic run_txn(input int d, input logic stray, input logic [DW-1:0] rdv, output int got);
        int   w;
        logic exp_err;
        w = rr_pick(m_req, model_last);
        n_txn++;
        bus_ready = stray;
        bus_rdata = $urandom;
        step();
        bus_ready = 1'b0;
        got = int'(grant_id);
        check_val("valid_rise", bus_valid, 1);
        check_val("busy_high", busy, 1);
        check_val("grant_id", grant_id, w);
        check_val("bus_addr", bus_addr, addr_a[w]);
        check_val("bus_rnw", bus_rnw, rnw_a[w]);
        check_val("bus_wdata", bus_wdata, wdata_a[w]);
        for (int k = 0; k < T; k++) begin
            bus_ready = (k == d);
            bus_rdata = (k == d) ? rdv : $urandom;
            step();
            bus_ready = 1'b0;
            if (k == d || k == T - 1) break;
            check_val("valid_hold", bus_valid, 1);
            check_val("no_early_done", m_done, 0);
        end
        exp_err = (d > T - 1);
        if (exp_err) model_rdata = '0;
        else if (rnw_a[w]) model_rdata = rdv;
        check_val("valid_fall", bus_valid, 0);
        check_val("m_done", m_done, 64'(1) << w);
        check_val("m_err", m_err, exp_err);
        check_val("m_rdata", m_rdata, model_rdata);
        $display("txn %0d: master %0d %s addr %08h ready_at %0d -> err %0d rdata %08h",
                 n_txn, w, rnw_a[w] ? "read " : "write", addr_a[w], d, m_err, m_rdata);
        clear_req(w);
        model_last = w;
        step();
        check_val("done_one_cycle", m_done, 0);
        check_val("idle_bubble", bus_valid, 0);
    endtask

    initial begin
        int g, d;
        rst = 1'b1;
        m_req = '0; m_rnw = '0; m_addr = '0; m_wdata = '0;
        bus_ready = 1'b0; bus_rdata = '0;
        model_last = N - 1;
        model_rdata = '0;
        step();
        step();
        check_val("rst_valid", bus_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", m_done, 0);
        check_val("rst_err", m_err, 0);
        check_val("rst_rdata", m_rdata, 0);
        check_val("rst_grant", grant_id, 0);
        check_val("rst_addr", bus_addr, 0);
        rst = 1'b0;
        step();

        // All masters requesting continuously: grants rotate 0,1,2,3,0.
        for (int i = 0; i < N; i++) set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
        for (int t = 0; t < 5; t++) begin
            run_txn(0, 1'b0, $urandom, g);
            check_val("rr_sequence", g, t % N);
            set_req(g, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
        for (int i = 0; i < N; i++) clear_req(i);
        step();

        // Single read with ready two cycles after bus_valid.
        set_req(0, 1'b1, 32'h8000_0000, 32'h0);
        run_txn(2, 1'b0, 32'hDEAD_BEEF, g);
        check_val("read_rdata", m_rdata, 32'hDEAD_BEEF);

        // Priority rotation: after master 2, request 0011 grants 0 then 1.
        set_req(2, 1'b1, $urandom, $urandom);
        run_txn(1, 1'b0, $urandom, g);
        set_req(0, 1'b1, $urandom, $urandom);
        set_req(1, 1'b0, $urandom, $urandom);
        run_txn(0, 1'b0, $urandom, g);
        check_val("rot_first", g, 0);
        run_txn(3, 1'b0, $urandom, g);
        check_val("rot_second", g, 1);

        // Timeout: ready never comes.
        set_req(0, 1'b1, $urandom, $urandom);
        run_txn(100, 1'b0, $urandom, g);
        check_val("timeout_err", m_err, 1);

        // Stray ready while idle, then master 3 writes.
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        check_val("stray_idle", busy, 0);
        set_req(3, 1'b0, 32'h8000_0004, 32'h1234_5678);
        run_txn(1, 1'b1, $urandom, g);
        check_val("write_keeps_rdata", m_rdata, 0);

        // Reset in the middle of a transaction.
        set_req(1, 1'b1, $urandom, $urandom);
        step();
        check_val("pre_rst_valid", bus_valid, 1);
        step();
        #2 rst = 1'b1;
        #1;
        check_val("rst_async_valid", bus_valid, 0);
        check_val("rst_async_busy", busy, 0);
        check_val("rst_async_done", m_done, 0);
        step();
        check_val("rst_no_done", m_done, 0);
        rst = 1'b0;
        clear_req(1);
        model_last = N - 1;
        model_rdata = '0;
        check_val("rst_rdata_clear", m_rdata, 0);
        for (int i = 0; i < N; i++) set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
        run_txn(0, 1'b0, $urandom, g);
        check_val("post_rst_prio", g, 0);

        // Random traffic.
        for (int t = 0; t < 200; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!m_req[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
            end
            if (m_req == '0) begin
                bus_ready = 1'($urandom_range(0, 1));
                step();
                bus_ready = 1'b0;
                check_val("rand_idle", busy, 0);
                continue;
            end
            d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(T - 2, T + 2)) : int'($urandom_range(0, 3));
            run_txn(d, 1'($urandom_range(0, 1)), $urandom, g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
